// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the single-ported main memory to the I-cache fill
// engine or the D-cache fill/writeback engine, one 4-word line burst at a time.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int WORDS   = 4,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [15:0] i_rdata,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [15:0] d_rdata,
   output logic        d_done,
   output logic [1:0]  word_idx,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

   state_t                  state;
   logic                    owner;       // 0 = I-cache, 1 = D-cache
   logic                    last_owner;
   logic                    wr;
   logic [12:0]             base;
   logic                    pick_d;
   logic [15:0]             pick_addr;
   logic [MEM_LAT-1:0]      rd_vld;
   logic [MEM_LAT-1:0][1:0] rd_idx;
   logic                    ret_vld;
   logic                    ret_last;
   logic                    unused_addr_bits;

   // D wins a tie unless it owned the previous burst
   assign pick_d    = d_req && (!i_req || !last_owner);
   assign pick_addr = pick_d ? d_addr : i_addr;
   assign ret_vld   = rd_vld[MEM_LAT-1];
   assign ret_last  = ret_vld && (rd_idx[MEM_LAT-1] == LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b0;
         wr         <= 1'b0;
         base       <= '0;
         word_idx   <= '0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         i_gnt      <= 1'b0;
         d_gnt      <= 1'b0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_req || d_req) begin
               state      <= ISSUE;
               owner      <= pick_d;
               last_owner <= pick_d;
               wr         <= pick_d && d_wr;
               base       <= pick_addr[15:3];
               word_idx   <= '0;
               mem_rd     <= !(pick_d && d_wr);
               mem_wr     <= pick_d && d_wr;
               mem_addr   <= {pick_addr[15:3], 3'b000};
               i_gnt      <= !pick_d;
               d_gnt      <= pick_d;
               busy       <= 1'b1;
            end
            ISSUE: if (word_idx == LAST_IDX) begin
               mem_rd   <= 1'b0;
               mem_wr   <= 1'b0;
               mem_addr <= '0;
               word_idx <= '0;
               if (wr) begin
                  state  <= DONE;
                  i_done <= !owner;
                  d_done <= owner;
               end else begin
                  state  <= DRAIN;
               end
            end else begin
               word_idx <= word_idx + 2'd1;
               mem_addr <= {base, word_idx + 2'd1, 1'b0};
            end
            DRAIN: if (ret_last) begin
               state  <= DONE;
               i_done <= !owner;
               d_done <= owner;
            end
            DONE: begin
               state  <= IDLE;
               i_gnt  <= 1'b0;
               d_gnt  <= 1'b0;
               i_done <= 1'b0;
               d_done <= 1'b0;
               busy   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-return tracker: each issued read walks MEM_LAT stages with its word index
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_vld <= '0;
         rd_idx <= '0;
      end else begin
         rd_vld[0] <= mem_rd;
         rd_idx[0] <= word_idx;
         for (int s = 1; s < MEM_LAT; s++) begin
            rd_vld[s] <= rd_vld[s-1];
            rd_idx[s] <= rd_idx[s-1];
         end
      end
   end

   assign i_rvalid  = ret_vld && !owner;
   assign d_rvalid  = ret_vld && owner;
   assign i_rdata   = i_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid ? mem_rdata : '0;
   assign mem_wdata = mem_wr ? d_wdata : '0;

   assign unused_addr_bits = ^{i_addr[2:0], d_addr[2:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=4 instance.
`timescale 1ns/1ps
module tb_mem_arbiter;

   typedef struct {
      int          cyc;
      logic [15:0] a;
      logic [15:0] b;
      logic        wr;
      logic        own;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata;
   logic i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_rd, mem_wr, busy;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0] word_idx;

   logic i_req4 = 1'b0;
   logic [15:0] i_addr4 = '0;
   logic i_gnt4, i_rvalid4, i_done4, d_gnt4, d_rvalid4, d_done4, mem_rd4, mem_wr4, busy4;
   logic [15:0] i_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
   logic [1:0] word_idx4;

   logic [15:0] mem [0:32767];
   logic [1:0]  rv2;
   logic [15:0] ra2 [2];
   logic [3:0]  rv4;
   logic [15:0] ra4 [4];

   int cyc = 0;
   int n_pass = 0, n_chk = 0;
   ev_t q_iss[$], q_irv[$], q_drv[$], q_idone[$], q_ddone[$], q4_rv[$], q4_done[$];
   ev_t me, me4, se;

   always #5 clk = ~clk;

   mem_arbiter #(.WORDS(4), .MEM_LAT(2)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
      .word_idx(word_idx), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.WORDS(4), .MEM_LAT(4)) dut4 (
      .clk(clk), .rst(rst),
      .i_req(i_req4), .i_addr(i_addr4), .i_gnt(i_gnt4), .i_rvalid(i_rvalid4), .i_rdata(i_rdata4), .i_done(i_done4),
      .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
      .d_gnt(d_gnt4), .d_rvalid(d_rvalid4), .d_rdata(d_rdata4), .d_done(d_done4),
      .word_idx(word_idx4), .mem_rd(mem_rd4), .mem_wr(mem_wr4), .mem_addr(mem_addr4),
      .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .busy(busy4)
   );

   // D-cache supplies word 0x1000 + word_idx during writebacks
   assign d_wdata = 16'h1000 + {14'd0, word_idx};

   // Memory model: fixed-latency reads, writes applied at the issuing edge
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rv2 <= '0;
         rv4 <= '0;
      end else begin
         rv2    <= {rv2[0], mem_rd};
         ra2[1] <= ra2[0];
         ra2[0] <= mem_addr;
         rv4    <= {rv4[2:0], mem_rd4};
         ra4[3] <= ra4[2];
         ra4[2] <= ra4[1];
         ra4[1] <= ra4[0];
         ra4[0] <= mem_addr4;
         if (mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
      end
   end
   assign mem_rdata  = rv2[1] ? mem[ra2[1][15:1]] : 16'hDEAD;
   assign mem_rdata4 = rv4[3] ? mem[ra4[3][15:1]] : 16'hDEAD;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Expected events of one burst whose first issue falls in cycle s
   task automatic push_burst(input bit own, input bit wr, input logic [15:0] addr,
                             input int s, input bit four);
      int lat = four ? 4 : 2;
      ev_t e;
      logic [15:0] a;
      for (int k = 0; k < 4; k++) begin
         a = (addr & 16'hFFF8) + 16'(2 * k);
         if (!four) begin
            e = '{cyc: s + k, a: a, b: 16'(16'h1000 + k), wr: wr, own: own};
            q_iss.push_back(e);
         end
         if (!wr) begin
            e = '{cyc: s + k + lat, a: a, b: mem[a[15:1]], wr: 1'b0, own: own};
            if (four) q4_rv.push_back(e);
            else if (own) q_drv.push_back(e);
            else q_irv.push_back(e);
         end
      end
      e = '{cyc: wr ? s + 4 : s + 4 + lat, a: '0, b: '0, wr: wr, own: own};
      if (four) q4_done.push_back(e);
      else if (own) q_ddone.push_back(e);
      else q_idone.push_back(e);
   endtask

   task automatic wait_dones(input int n);
      int seen = 0;
      for (int t = 0; t < 40 * n && seen < n; t++) begin
         @(negedge clk);
         if (i_done || d_done || i_done4) seen++;
      end
      chk("done_count", seen, n);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      chk("q_left", q_iss.size() + q_irv.size() + q_drv.size() + q_idone.size()
                    + q_ddone.size() + q4_rv.size() + q4_done.size(), 0);
   endtask

   always @(negedge clk) begin
      if (mem_rd || mem_wr) begin
         if (q_iss.size() == 0) chk("iss_unexp", 1, 0);
         else begin
            me = q_iss.pop_front();
            chk("iss_cyc", cyc, me.cyc);
            chk("iss_addr", mem_addr, me.a);
            chk("iss_wr", {mem_rd, mem_wr}, {!me.wr, me.wr});
            if (me.wr) chk("iss_wdata", mem_wdata, me.b);
            chk("iss_gnt", {i_gnt, d_gnt}, me.own ? 2'b01 : 2'b10);
         end
      end
      if (i_rvalid) begin
         if (q_irv.size() == 0) chk("irv_unexp", 1, 0);
         else begin
            me = q_irv.pop_front();
            chk("irv_cyc", cyc, me.cyc);
            chk("irv_data", i_rdata, me.b);
         end
      end
      if (d_rvalid) begin
         if (q_drv.size() == 0) chk("drv_unexp", 1, 0);
         else begin
            me = q_drv.pop_front();
            chk("drv_cyc", cyc, me.cyc);
            chk("drv_data", d_rdata, me.b);
         end
      end
      if (i_done) begin
         if (q_idone.size() == 0) chk("idone_unexp", 1, 0);
         else begin
            me = q_idone.pop_front();
            chk("idone_cyc", cyc, me.cyc);
         end
      end
      if (d_done) begin
         if (q_ddone.size() == 0) chk("ddone_unexp", 1, 0);
         else begin
            me = q_ddone.pop_front();
            chk("ddone_cyc", cyc, me.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (i_rvalid4) begin
         if (q4_rv.size() == 0) chk("rv4_unexp", 1, 0);
         else begin
            me4 = q4_rv.pop_front();
            chk("rv4_cyc", cyc, me4.cyc);
            chk("rv4_data", i_rdata4, me4.b);
         end
      end
      if (i_done4) begin
         if (q4_done.size() == 0) chk("done4_unexp", 1, 0);
         else begin
            me4 = q4_done.pop_front();
            chk("done4_cyc", cyc, me4.cyc);
         end
      end
   end

   initial begin
      int b;
      for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 7) ^ 16'h5A5A;
      mem[16'h1230 >> 1] = 16'hA0A0;
      mem[16'h1232 >> 1] = 16'hB1B1;
      mem[16'h1234 >> 1] = 16'hC2C2;
      mem[16'h1236 >> 1] = 16'hD3D3;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_hs", {i_gnt, d_gnt, i_done, d_done, i_rvalid, d_rvalid}, 0);
      chk("rst_mem", {mem_rd, mem_wr, word_idx, mem_addr}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);

      // I-cache read alone
      i_addr = 16'h1235; i_req = 1'b1;
      push_burst(1'b0, 1'b0, 16'h1235, cyc + 1, 1'b0);
      wait_dones(1); i_req = 1'b0;
      settle();

      // D-cache writeback, then read the line back
      d_addr = 16'h0040; d_wr = 1'b1; d_req = 1'b1;
      push_burst(1'b1, 1'b1, 16'h0040, cyc + 1, 1'b0);
      wait_dones(1); d_req = 1'b0; d_wr = 1'b0;
      settle();
      d_req = 1'b1;
      push_burst(1'b1, 1'b0, 16'h0040, cyc + 1, 1'b0);
      wait_dones(1); d_req = 1'b0;
      settle();
      chk("wb_mem0", mem[16'h0040 >> 1], 16'h1000);

      // Ties after reset: D, then I, then D again
      rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
      i_addr = 16'h3008; d_addr = 16'h2000; i_req = 1'b1; d_req = 1'b1;
      b = cyc;
      push_burst(1'b1, 1'b0, 16'h2000, b + 1, 1'b0);
      push_burst(1'b0, 1'b0, 16'h3008, b + 9, 1'b0);
      push_burst(1'b1, 1'b0, 16'h2000, b + 17, 1'b0);
      wait_dones(3); i_req = 1'b0; d_req = 1'b0;
      settle();

      // Top of address space
      d_addr = 16'hFFFF; d_req = 1'b1;
      push_burst(1'b1, 1'b0, 16'hFFFF, cyc + 1, 1'b0);
      wait_dones(1); d_req = 1'b0;
      settle();

      // Reset in c4 of an I-cache read: only issues c1..c3 and word 0 survive
      i_addr = 16'h1235; i_req = 1'b1;
      b = cyc;
      for (int k = 0; k < 3; k++) begin
         se = '{cyc: b + 1 + k, a: 16'(16'h1230 + 2 * k), b: '0, wr: 1'b0, own: 1'b0};
         q_iss.push_back(se);
      end
      se = '{cyc: b + 3, a: 16'h1230, b: 16'hA0A0, wr: 1'b0, own: 1'b0};
      q_irv.push_back(se);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0; i_req = 1'b0;
      #1;
      chk("mid_rst_hs", {i_gnt, d_gnt, i_done, d_done, i_rvalid, d_rvalid, busy}, 0);
      chk("mid_rst_mem", {mem_rd, mem_wr, word_idx, mem_addr}, 0);
      chk("mid_rst_data", {i_rdata, d_rdata}, 0);
      chk("mid_rst_wdata", mem_wdata, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      settle();
      d_addr = 16'h0100; d_req = 1'b1;
      push_burst(1'b1, 1'b0, 16'h0100, cyc + 1, 1'b0);
      wait_dones(1); d_req = 1'b0;
      settle();

      // MEM_LAT=4 instance
      i_addr4 = 16'h1230; i_req4 = 1'b1;
      push_burst(1'b0, 1'b0, 16'h1230, cyc + 1, 1'b1);
      wait_dones(1); i_req4 = 1'b0;
      settle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
